// File: rtl/hsk_protocol_monitor.sv
// Passive multi-channel valid/ready monitor: sticky violation flags plus saturating transfer counters.
// Optional macro HSK_MON_ASSERT_EN compiles in per-channel concurrent assertions.
module hsk_protocol_monitor #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [NUM_CH-1:0]        valid,
   input  logic [NUM_CH-1:0]        ready,
   input  logic [NUM_CH*DATA_W-1:0] data,
   output logic [NUM_CH-1:0]        err_drop,
   output logic [NUM_CH-1:0]        err_data,
   output logic [NUM_CH-1:0]        err_timeout,
   output logic                     any_err,
   output logic [NUM_CH*CNT_W-1:0]  xfer_cnt
);

   localparam int STALL_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(TIMEOUT);
   localparam logic [STALL_W-1:0] STALL_FIRST = (TIMEOUT == 0) ? '0 : STALL_W'(1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   logic [NUM_CH-1:0] drop_nxt;
   logic [NUM_CH-1:0] data_nxt;
   logic [NUM_CH-1:0] to_nxt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [0:0]         state;
      logic [0:0]         state_nxt;
      logic [DATA_W-1:0]  cap;
      logic [DATA_W-1:0]  cap_nxt;
      logic [DATA_W-1:0]  din;
      logic [STALL_W-1:0] stall;
      logic [STALL_W-1:0] stall_nxt;
      logic [CNT_W-1:0]   cnt;
      logic               ev_xfer;
      logic               ev_drop;
      logic               ev_data;
      logic               ev_to;

      assign din = data[i*DATA_W +: DATA_W];

      always_comb begin
         state_nxt = state;
         cap_nxt   = cap;
         stall_nxt = stall;
         ev_xfer   = 1'b0;
         ev_drop   = 1'b0;
         ev_data   = 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid[i]) begin
                  if (ready[i]) begin
                     ev_xfer = 1'b1;
                  end else begin
                     state_nxt = ST_PEND;
                     cap_nxt   = din;
                     stall_nxt = STALL_FIRST;
                  end
               end
            end
            default: begin
               if (!valid[i]) begin
                  ev_drop   = 1'b1;
                  state_nxt = ST_IDLE;
                  stall_nxt = '0;
               end else begin
                  // Captured value is held, so every differing cycle is compared to the original.
                  ev_data = (din != cap);
                  if (ready[i]) begin
                     ev_xfer   = 1'b1;
                     state_nxt = ST_IDLE;
                     stall_nxt = '0;
                  end else if (stall != STALL_MAX) begin
                     stall_nxt = stall + 1'b1;
                  end
               end
            end
         endcase
         // Fires only on the cycle the stall count first arrives at the limit; no re-arm while pending.
         ev_to = (TIMEOUT != 0) && (state_nxt == ST_PEND) && (stall_nxt == STALL_MAX)
                 && !((state == ST_PEND) && (stall == STALL_MAX));
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state <= ST_IDLE;
            cap   <= '0;
            stall <= '0;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cap   <= cap_nxt;
            stall <= stall_nxt;
            if (clr) begin
               cnt <= '0;
            end else if (ev_xfer && (cnt != '1)) begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign xfer_cnt[i*CNT_W +: CNT_W] = cnt;
      assign drop_nxt[i] = ~clr & (err_drop[i]    | ev_drop);
      assign data_nxt[i] = ~clr & (err_data[i]    | ev_data);
      assign to_nxt[i]   = ~clr & (err_timeout[i] | ev_to);

`ifdef HSK_MON_ASSERT_EN
      a_valid_hold: assert property (@(posedge clk) disable iff (rst)
         (valid[i] && !ready[i]) |=> valid[i])
         else $error("hsk_protocol_monitor: valid dropped while pending on channel %0d", i);

      a_data_stable: assert property (@(posedge clk) disable iff (rst)
         (valid[i] && !ready[i]) |=> $stable(din))
         else $error("hsk_protocol_monitor: data changed while pending on channel %0d", i);

      if (TIMEOUT != 0) begin : g_to_chk
         a_no_timeout: assert property (@(posedge clk) disable iff (rst) !ev_to)
            else $error("hsk_protocol_monitor: stall timeout on channel %0d", i);
      end
`else
      // Flags are the only reporting path in this build.
`endif
   end

   // any_err is built from next-state flags so it lands on the same edge as the flag itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_drop    <= '0;
         err_data    <= '0;
         err_timeout <= '0;
         any_err     <= 1'b0;
      end else begin
         err_drop    <= drop_nxt;
         err_data    <= data_nxt;
         err_timeout <= to_nxt;
         any_err     <= |{drop_nxt, data_nxt, to_nxt};
      end
   end

endmodule

// File: tb/tb_hsk_protocol_monitor.sv
// Scoreboard bench for hsk_protocol_monitor (NUM_CH=4, DATA_W=8, CNT_W=2, TIMEOUT=4).
module tb_hsk_protocol_monitor;

   logic        clk;
   logic        rst;
   logic        clr;
   logic [3:0]  valid;
   logic [3:0]  ready;
   logic [31:0] data;
   logic [3:0]  err_drop;
   logic [3:0]  err_data;
   logic [3:0]  err_timeout;
   logic        any_err;
   logic [7:0]  xfer_cnt;

   typedef struct {
      int         step;
      logic [3:0] drop;
      logic [3:0] dat;
      logic [3:0] to;
      logic       any;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   step_id = 0;
   int   checks  = 0;
   int   passes  = 0;

   hsk_protocol_monitor #(
      .NUM_CH (4),
      .DATA_W (8),
      .CNT_W  (2),
      .TIMEOUT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .valid      (valid),
      .ready      (ready),
      .data       (data),
      .err_drop   (err_drop),
      .err_data   (err_data),
      .err_timeout(err_timeout),
      .any_err    (any_err),
      .xfer_cnt   (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] cnts(input logic [1:0] c3, c2, c1, c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic compareField(input string name, input int step, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, step, act, req);
   endtask

   task automatic checkOutput(input exp_t e);
      compareField("err_drop",    e.step, {4'b0, err_drop},    {4'b0, e.drop});
      compareField("err_data",    e.step, {4'b0, err_data},    {4'b0, e.dat});
      compareField("err_timeout", e.step, {4'b0, err_timeout}, {4'b0, e.to});
      compareField("any_err",     e.step, {7'b0, any_err},     {7'b0, e.any});
      compareField("xfer_cnt",    e.step, xfer_cnt,            e.cnt);
   endtask

   // One call is one clock: drive at negedge, queue what the outputs must be after the next posedge.
   task automatic applyStimulus(input logic r, input logic c, input logic [3:0] v, input logic [3:0] rd,
                                input logic [31:0] d, input logic [3:0] ed, input logic [3:0] edt,
                                input logic [3:0] eto, input logic ea, input logic [7:0] ec);
      exp_t e;
      @(negedge clk);
      rst   = r;
      clr   = c;
      valid = v;
      ready = rd;
      data  = d;
      e.step = step_id;
      e.drop = ed;
      e.dat  = edt;
      e.to   = eto;
      e.any  = ea;
      e.cnt  = ec;
      step_id++;
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; clr = 1'b0; valid = '0; ready = '0; data = '0;

      // Reset with random traffic, then three ch0 handshakes
      applyStimulus(1, 0, 4'($urandom), 4'($urandom), $urandom, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(1, 0, 4'($urandom), 4'($urandom), $urandom, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,1));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,2));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));

      // Valid drop on ch1
      applyStimulus(0, 0, 4'b0010, 4'b0000, 32'h0000_A500, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));
      applyStimulus(0, 0, 4'b0010, 4'b0000, 32'h0000_A500, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));
      applyStimulus(0, 0, 4'b0000, 4'b0000, 32'h0000_A500, 4'h2, 4'h0, 4'h0, 1, cnts(0,0,0,3));

      // Data instability on ch2, then handshake
      applyStimulus(0, 0, 4'b0100, 4'b0000, 32'h003C_0000, 4'h2, 4'h0, 4'h0, 1, cnts(0,0,0,3));
      applyStimulus(0, 0, 4'b0100, 4'b0000, 32'h003D_0000, 4'h2, 4'h4, 4'h0, 1, cnts(0,0,0,3));
      applyStimulus(0, 0, 4'b0100, 4'b0100, 32'h003D_0000, 4'h2, 4'h4, 4'h0, 1, cnts(0,1,0,3));

      // Stall timeout on ch3: flag on the fourth stall cycle only
      applyStimulus(0, 0, 4'b1000, 4'b0000, 32'h7700_0000, 4'h2, 4'h4, 4'h0, 1, cnts(0,1,0,3));
      applyStimulus(0, 0, 4'b1000, 4'b0000, 32'h7700_0000, 4'h2, 4'h4, 4'h0, 1, cnts(0,1,0,3));
      applyStimulus(0, 0, 4'b1000, 4'b0000, 32'h7700_0000, 4'h2, 4'h4, 4'h0, 1, cnts(0,1,0,3));
      applyStimulus(0, 0, 4'b1000, 4'b0000, 32'h7700_0000, 4'h2, 4'h4, 4'h8, 1, cnts(0,1,0,3));
      applyStimulus(0, 0, 4'b1000, 4'b1000, 32'h7700_0000, 4'h2, 4'h4, 4'h8, 1, cnts(1,1,0,3));

      // Clear, then counter saturation at 3
      applyStimulus(0, 1, 4'b0000, 4'b0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,1));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,2));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));

      // clr coincident with a ch1 valid drop discards the drop
      applyStimulus(0, 0, 4'b0010, 4'b0000, 32'h0000_A500, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,3));
      applyStimulus(0, 1, 4'b0000, 4'b0000, 32'h0000_A500, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b0000, 4'b0000, 32'h0000_A500, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));

      // clr while pending keeps the captured value (0x12) for later comparison
      applyStimulus(0, 0, 4'b0001, 4'b0000, 32'h0000_0012, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 1, 4'b0001, 4'b0000, 32'h0000_0012, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b0001, 4'b0000, 32'h0000_0013, 4'h0, 4'h1, 4'h0, 1, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b0001, 4'b0001, 32'h0000_0013, 4'h0, 4'h1, 4'h0, 1, cnts(0,0,0,1));
      applyStimulus(0, 1, 4'b0000, 4'b0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));

      // Good case: all channels stall twice then handshake with stable data
      applyStimulus(0, 0, 4'b1111, 4'b0000, 32'h4433_2211, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b1111, 4'b0000, 32'h4433_2211, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b1111, 4'b1111, 32'h4433_2211, 4'h0, 4'h0, 4'h0, 0, cnts(1,1,1,1));
      applyStimulus(0, 0, 4'b0000, 4'b0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(1,1,1,1));

      // rst while ch2 is pending discards the transfer without a flag
      applyStimulus(0, 0, 4'b0100, 4'b0000, 32'h0055_0000, 4'h0, 4'h0, 4'h0, 0, cnts(1,1,1,1));
      applyStimulus(1, 0, 4'b0000, 4'b0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));
      applyStimulus(0, 0, 4'b0000, 4'b0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, cnts(0,0,0,0));

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
